vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- Timing generator for the 640x480 @ 60 Hz VGA output path.
- Counts pixel clocks into horizontal and vertical positions.
- Drives hsync/vsync to the connector and row/column/display-enable to the RGB pixel-colour stage.
- Upstream producer of the row_i/column_i coordinates that the colour stage consumes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk_i  input  1  pixel clock, 25 MHz (50 MHz when VGA_CLK_DIV2_EN is defined)
rst_ni  input  1  asynchronous active-low reset
hsync_o  output  1  horizontal sync, active low
vsync_o  output  1  vertical sync, active low
de_o  output  1  display enable, high inside the 640x480 visible area
row_o  output  9  visible line index 0..479; 0 outside the visible area
column_o  output  10  visible pixel index 0..639; 0 outside the visible area
frame_start_o  output  1  one-cycle pulse coincident with pixel (0,0)
pix_en_o  output  1  pixel-advance qualifier for downstream logic

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: h_cnt=0, v_cnt=0, hsync_o=1, vsync_o=1, de_o=0, row_o=0, column_o=0, frame_start_o=0, pix_en_o=0.
- Derived totals:
  - H_TOTAL = sum of the H parameters = 800.
  - V_TOTAL = sum of the V parameters = 525.
- Internal counters: h_cnt and v_cnt, each 10 bits. Counter width is ceil(log2(total)).
- On each advancing cycle:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - If v_cnt = V_TOTAL-1 at the same time, v_cnt also wraps to 0 (simultaneous wrap).
- Decodes, computed from the counters:
  - hsync low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - de high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - column_o = de ? h_cnt[9:0] : 0.
  - row_o = de ? v_cnt[8:0] : 0.
  - frame_start high when h_cnt = 0 and v_cnt = 0.
- Output registration and latency:
  - All outputs are registered.
  - Outputs reflect the counter values of the previous advancing cycle, so latency is 1 pixel.
  - All outputs are mutually aligned.
  - First output update after reset release: de_o=1, row_o=0, column_o=0, frame_start_o=1.
- Frame period: 420000 advancing cycles.
  - frame_start_o pulses exactly once per frame.
  - de_o is high for 307200 advancing cycles per frame.
- Reset asserted mid-frame: counters and outputs return to reset values immediately (asynchronously). After release, a new frame starts at (0,0).
- No external stall. The counters are free-running.

Optional Feature:
Macro: VGA_CLK_DIV2_EN
- Defined:
  - clk_i is 50 MHz.
  - An internal toggle flop (reset 0) produces the advance tick on alternate cycles.
  - Counters and output registers update only when the tick is 1; otherwise they hold.
  - pix_en_o equals the tick, so it toggles 0,1,0,1... after reset.
  - frame_start_o is high for the 2 clk_i cycles of its pixel.
- Not defined:
  - Every clk_i cycle is an advancing cycle.
  - pix_en_o is 1 from the first clock edge after reset release.

Decomposition:
- Shared package vga_pkg:
  - Timing constants for 640x480 (H_ACTIVE..V_BP).
  - H_TOTAL, V_TOTAL.
  - Counter width localparams.
  - Colour constants (RED, GREEN, BLUE, CYAN, 3-bit) shared with the RGB stage.
- One natural sub-module: vga_axis_counter.
  - Parameterised by total, active, front-porch and sync lengths.
  - Outputs: count, active flag, sync flag and wrap pulse.
  - Instantiated twice: horizontal (advance = tick) and vertical (advance = horizontal wrap pulse).

Test Plan:
- Reset held 10 cycles, then released → during reset all outputs at reset values; first update shows de_o=1, row_o=0, column_o=0, frame_start_o=1.
- Line 0 timing → hsync_o low for exactly 96 cycles, starting 656 cycles after the line start; de_o high for exactly 640 cycles per line; column_o runs 0..639, then 0.
- Full frame → frame_start_o pulses 420000 cycles apart; vsync_o low for 1600 cycles, starting at line 490; 307200 de_o cycles per frame; row_o reaches 479 and never 480.
- Boundary at h=799, v=524 → the next output shows frame_start_o=1, row_o=0, column_o=0 (simultaneous wrap).
- rst_ni pulsed low at line 200, pixel 300 → outputs go to reset values asynchronously; after release the frame restarts at (0,0) with a full 420000-cycle period.
- VGA_CLK_DIV2_EN defined, same run → all periods double (840000 clk_i per frame, hsync low 192 clk_i); pix_en_o alternates; outputs change only on pix_en_o=1 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter widths, output bundle type and
// the colour codes used by the downstream RGB stage.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_CNT_W = $clog2(H_TOTAL);
  localparam int V_CNT_W = $clog2(V_TOTAL);
  localparam int ROW_W   = 9;
  localparam int COL_W   = 10;

  typedef logic [2:0] rgb_t;
  localparam rgb_t RED   = 3'b100;
  localparam rgb_t GREEN = 3'b010;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t CYAN  = 3'b011;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] column;
    logic             frame_start;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RST = '{
    hsync:       1'b1,
    vsync:       1'b1,
    de:          1'b0,
    row:         '0,
    column:      '0,
    frame_start: 1'b0
  };

endpackage

// File: rtl/vga_sync_gen_axis.sv
// One timing axis: free-running wrap counter with active-region and sync-region
// flags, plus a wrap pulse that advances the next axis.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL  = H_TOTAL,
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int W      = H_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         adv_i,
  output logic [W-1:0] count_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST_C    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_C     = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO_C = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI_C = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_q, count_d;
  logic         last;

  always_comb begin
    last    = (count_q == LAST_C);
    count_d = count_q;
    if (adv_i) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o  = count_q;
  assign active_o = (count_q < ACT_C);
  assign sync_o   = (count_q >= SYNC_LO_C) && (count_q < SYNC_HI_C);
  assign wrap_o   = adv_i && last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/position generator with registered, mutually aligned outputs.
// Define VGA_CLK_DIV2_EN to run from a 2x pixel clock (advance on alternate cycles).
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_FP_P     = H_FP,
  parameter int H_SYNC_P   = H_SYNC,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_FP_P     = V_FP,
  parameter int V_SYNC_P   = V_SYNC,
  parameter int V_BP_P     = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] column_o,
  output logic             frame_start_o,
  output logic             pix_en_o
);

  localparam int H_TOTAL_P = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int V_TOTAL_P = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

  logic tick;

`ifdef VGA_CLK_DIV2_EN
  logic tick_q, tick_d;

  always_comb tick_d = ~tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= 1'b0;
    else         tick_q <= tick_d;
  end

  assign tick     = tick_q;
  assign pix_en_o = tick_q;
`else
  logic pix_en_q, pix_en_d;

  always_comb pix_en_d = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pix_en_q <= 1'b0;
    else         pix_en_q <= pix_en_d;
  end

  assign tick     = 1'b1;
  assign pix_en_o = pix_en_q;
`endif

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_active, h_sync, h_wrap;
  logic               v_active, v_sync, v_wrap_unused;

  vga_axis_counter #(
    .TOTAL (H_TOTAL_P),
    .ACTIVE(H_ACTIVE_P),
    .FP    (H_FP_P),
    .SYNC  (H_SYNC_P),
    .W     (H_CNT_W)
  ) u_h_axis (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .adv_i   (tick),
    .count_o (h_cnt),
    .active_o(h_active),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  // Vertical axis steps once per line; the frame wrap needs no extra logic.
  vga_axis_counter #(
    .TOTAL (V_TOTAL_P),
    .ACTIVE(V_ACTIVE_P),
    .FP    (V_FP_P),
    .SYNC  (V_SYNC_P),
    .W     (V_CNT_W)
  ) u_v_axis (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .adv_i   (h_wrap),
    .count_o (v_cnt),
    .active_o(v_active),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap_unused)
  );

  vga_out_t dec;
  vga_out_t out_q, out_d;

  always_comb begin
    dec.hsync       = ~h_sync;
    dec.vsync       = ~v_sync;
    dec.de          = h_active && v_active;
    dec.row         = '0;
    dec.column      = '0;
    dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    if (dec.de) begin
      dec.row    = v_cnt[ROW_W-1:0];
      dec.column = h_cnt[COL_W-1:0];
    end
    out_d = tick ? dec : out_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= VGA_OUT_RST;
    else         out_q <= out_d;
  end

  assign hsync_o       = out_q.hsync;
  assign vsync_o       = out_q.vsync;
  assign de_o          = out_q.de;
  assign row_o         = out_q.row;
  assign column_o      = out_q.column;
  assign frame_start_o = out_q.frame_start;

endmodule
